pll_supervisor: RTL and testbench
=================================

PLL_SUPERVISOR -- requirements
Module: pll_supervisor

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16: clk cycles pll_rst is held high per reset pulse (minimum 1).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 50000: clk cycles to wait for lock after a reset pulse (1 ms at 50 MHz).
REQ-003 SHALL have parameter STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before release.
REQ-004 SHALL have parameter MAX_RETRIES, default 3, range 0..7: timeout retries before FAIL.
REQ-005 Ports, clock and reset first: one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  PLL reference clock (board oscillator, free-running), sole clock.
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 lock  input  1  PLL LOCK output, asynchronous to clk.
REQ-009 pll_rst  output  1  drives the PLL RESET input, active high.
REQ-010 sys_reset_n  output  1  active-low reset for logic clocked by the PLL output.
REQ-011 ready  output  1  high only in state RUN.
REQ-012 fail  output  1  high only in state FAIL.
REQ-013 retry_cnt  output  3  timeout retries in the current lock attempt.
REQ-014 lock_lost  output  1  sticky flag: lock lost at least once while in RUN.

Function
REQ-015 SHALL synchronize lock through two flops to lock_s; lock_s alone drives all decisions.
REQ-016 SHALL implement states PLL_RST, WAIT_LOCK, STABLE, RUN and FAIL with one shared counter, sized for the largest parameter and cleared on every state change.
REQ-017 PLL_RST: pll_rst=1; after PLL_RST_CYCLES cycles SHALL go to WAIT_LOCK.
REQ-018 WAIT_LOCK: if lock_s=1, SHALL go to STABLE; after LOCK_TIMEOUT cycles without lock_s, SHALL go to PLL_RST with retry_cnt+1 if retry_cnt<MAX_RETRIES, otherwise to FAIL.
REQ-019 STABLE: lock_s=0 SHALL return to WAIT_LOCK with a fresh timeout; after STABLE_CYCLES consecutive lock_s=1 cycles SHALL go to RUN.
REQ-020 RUN: sys_reset_n=1 and ready=1; a lock loss (REQ-027) SHALL set lock_lost, clear retry_cnt, and go to PLL_RST.
REQ-021 FAIL: pll_rst=0, sys_reset_n=0, fail=1; SHALL be exited only by reset_n.
REQ-022 All outputs SHALL be registered; sys_reset_n SHALL be 0 in every state except RUN.
REQ-023 sys_reset_n SHALL rise exactly STABLE_CYCLES+3 clk edges after the first edge that samples lock=1, given a stable lock.
REQ-024 sys_reset_n SHALL fall on the clk edge after lock_s is first seen low in RUN (filter off).
REQ-025 retry_cnt SHALL never exceed MAX_RETRIES and SHALL hold its value in FAIL.

Reset
REQ-026 With reset_n low, all logic SHALL immediately take these values, including mid-operation: state PLL_RST, counter 0, pll_rst=1, sys_reset_n=0, ready=0, fail=0, retry_cnt=0, lock_lost=0, and both sync flops at 0.

Configuration
REQ-027 With the macro PLLSUP_GLITCH_FILTER_EN defined, RUN SHALL treat lock as lost only after 4 consecutive lock_s=0 cycles, and a shorter drop SHALL have no effect. Without the macro, a single lock_s=0 cycle in RUN is a loss. STABLE behaviour is unaffected either way.

Verification (PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2)
REQ-028 Release reset; lock rises 5 cycles after pll_rst falls and stays high. Required: pll_rst high for exactly 4 cycles, sys_reset_n and ready rise 11 edges after lock is first sampled high.
REQ-029 lock held low. Required: 3 pll_rst pulses of 4 cycles each, 20 cycles apart, then fail=1, retry_cnt=2, sys_reset_n=0, and no further pulses.
REQ-030 In STABLE, lock drops for 1 cycle at stable count 5. Required: return to WAIT_LOCK, then RUN reached only 8 full lock_s cycles after recovery.
REQ-031 In RUN with the filter off, lock goes low for 3 cycles. Required: lock_lost=1, sys_reset_n=0 and a 4-cycle pll_rst pulse, with retry_cnt=0.
REQ-032 PLLSUP_GLITCH_FILTER_EN defined, in RUN. Required: a 3-cycle lock drop leaves ready=1 and lock_lost=0; a 6-cycle drop causes a loss as in REQ-031.
REQ-033 reset_n pulsed low mid-RUN, and then mid-FAIL. Required: all outputs take their REQ-026 values asynchronously, and the sequence restarts with a PLL_RST pulse.

Source files
------------

// File: rtl/pll_supervisor_if.sv
// Bundle of the PLL-facing and system-facing signals of pll_supervisor.
//   master : the supervisor (samples lock, drives the reset/status outputs)
//   slave  : the PLL / system side (drives lock, observes the outputs)
//   lock        - PLL LOCK output, asynchronous to the supervisor clock
//   pll_rst     - PLL RESET input, active high
//   sys_reset_n - active-low reset for logic clocked by the PLL output
//   ready       - high only while the supervisor is in RUN
//   fail        - high only while the supervisor is in FAIL
//   retry_cnt   - timeout retries in the current lock attempt
//   lock_lost   - sticky: lock was lost at least once while in RUN
interface pll_supervisor_if;
  localparam int unsigned RETRY_W = 3;

  logic               lock;
  logic               pll_rst;
  logic               sys_reset_n;
  logic               ready;
  logic               fail;
  logic [RETRY_W-1:0] retry_cnt;
  logic               lock_lost;

  modport master (
    input  lock,
    output pll_rst, sys_reset_n, ready, fail, retry_cnt, lock_lost
  );

  modport slave (
    output lock,
    input  pll_rst, sys_reset_n, ready, fail, retry_cnt, lock_lost
  );
endinterface

// File: rtl/pll_supervisor.sv
// PLL reset sequencer and lock supervisor.
// Pulses the PLL reset, waits for lock with a timeout and bounded retries,
// requires a stable lock before releasing the system reset, and restarts
// the sequence when lock is lost while running.
// Ports:
//   clk      - free-running reference clock (sole clock)
//   reset_n  - asynchronous active-low reset
//   bus      - pll_supervisor_if.master (lock in; pll_rst, sys_reset_n,
//              ready, fail, retry_cnt, lock_lost out, all registered)
// Optional feature: define PLLSUP_GLITCH_FILTER_EN to ignore lock drops in
// RUN shorter than 4 consecutive synchronized cycles.
module pll_supervisor #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 50000,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  pll_supervisor_if.master bus
);

  localparam int unsigned GLITCH_CYCLES = 4;
  localparam int unsigned MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_B   = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int unsigned CNT_MAX = (MAX_B > GLITCH_CYCLES) ? MAX_B : GLITCH_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned RETRY_W = 3;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [RETRY_W-1:0] retry_q, retry_nx;
  logic               lost_q, lost_nx;
  logic               loss_c;
  logic               run_c;
  logic               lock_meta, lock_s;
  logic               pll_rst_q, sys_reset_n_q, ready_q, fail_q;

  // Two-flop synchronizer for the asynchronous lock input
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= bus.lock;
      lock_s    <= lock_meta;
    end
  end

  // State, shared counter, retry/lock-lost bookkeeping and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_PLL_RST;
      cnt           <= '0;
      retry_q       <= '0;
      lost_q        <= 1'b0;
      pll_rst_q     <= 1'b1;
      sys_reset_n_q <= 1'b0;
      ready_q       <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      retry_q       <= retry_nx;
      lost_q        <= lost_nx;
      pll_rst_q     <= (state_nx == ST_PLL_RST);
      sys_reset_n_q <= run_c;
      ready_q       <= run_c;
      fail_q        <= (state_nx == ST_FAIL);
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CNT_W'(1);
    retry_nx = retry_q;
    lost_nx  = lost_q;
    loss_c   = 1'b0;

    case (state)
      ST_PLL_RST: begin
        if (cnt == CNT_W'(PLL_RST_CYCLES - 1)) state_nx = ST_WAIT_LOCK;
      end

      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_nx = ST_STABLE;
        end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
          if (retry_q < RETRY_W'(MAX_RETRIES)) begin
            state_nx = ST_PLL_RST;
            retry_nx = retry_q + RETRY_W'(1);
          end else begin
            state_nx = ST_FAIL;
          end
        end
      end

      ST_STABLE: begin
        if (!lock_s) begin
          state_nx = ST_WAIT_LOCK;
        end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
          state_nx = ST_RUN;
        end
      end

      ST_RUN: begin
`ifdef PLLSUP_GLITCH_FILTER_EN
        // Counter tracks consecutive low cycles; any high sample restarts it
        if (lock_s) begin
          cnt_nx = '0;
        end else if (cnt == CNT_W'(GLITCH_CYCLES - 1)) begin
          loss_c = 1'b1;
        end
`else
        cnt_nx = '0;
        loss_c = !lock_s;
`endif
        if (loss_c) begin
          state_nx = ST_PLL_RST;
          retry_nx = '0;
          lost_nx  = 1'b1;
        end
      end

      ST_FAIL: begin
        cnt_nx = cnt;
      end

      default: begin
        state_nx = ST_PLL_RST;
      end
    endcase

    if (state_nx != state) cnt_nx = '0;
  end

  // Release lands one cycle after RUN entry; deassert on the exit edge itself
  assign run_c = (state == ST_RUN) && (state_nx == ST_RUN);

  assign bus.pll_rst     = pll_rst_q;
  assign bus.sys_reset_n = sys_reset_n_q;
  assign bus.ready       = ready_q;
  assign bus.fail        = fail_q;
  assign bus.retry_cnt   = retry_q;
  assign bus.lock_lost   = lost_q;

endmodule

// File: tb/tb_pll_supervisor.sv
// Scoreboard bench for pll_supervisor. Stimulus pushes each expected output
// change (cycle stamp + output vector) into a queue; the monitor pops an entry
// whenever the sampled outputs change and compares value and cycle.
// Output vector field order: {pll_rst, sys_reset_n, ready, fail, retry_cnt[2:0], lock_lost}
module tb_pll_supervisor;
  localparam int unsigned P_RST = 4;
  localparam int unsigned P_TO  = 20;
  localparam int unsigned P_ST  = 8;
  localparam int unsigned P_MR  = 2;
`ifdef PLLSUP_GLITCH_FILTER_EN
  localparam int unsigned LOSS_DLY = 4;
  localparam int unsigned DROP_LEN = 6;
`else
  localparam int unsigned LOSS_DLY = 1;
  localparam int unsigned DROP_LEN = 3;
`endif

  typedef struct {
    int unsigned cyc;
    logic [7:0]  v;
  } ev_t;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b1;
  int unsigned cyc     = 0;
  int          checks  = 0;
  int          errors  = 0;
  ev_t         exp_q[$];
  ev_t         mon_e;
  bit          mon_en    = 1'b0;
  bit          have_prev = 1'b0;
  logic [7:0]  prev;
  logic [7:0]  cur;

  pll_supervisor_if bus();

  pll_supervisor #(
    .PLL_RST_CYCLES (P_RST),
    .LOCK_TIMEOUT   (P_TO),
    .STABLE_CYCLES  (P_ST),
    .MAX_RETRIES    (P_MR)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int unsigned c, input logic [7:0] v);
    ev_t e;
    e.cyc = c;
    e.v   = v;
    exp_q.push_back(e);
  endtask

  // Asserts reset_n mid-cycle; outputs must take reset values immediately
  task automatic hit_reset(input int n, output int unsigned r);
    push(cyc, 8'b1_0_0_0_000_0);
    bus.lock = 1'b0;
    reset_n  = 1'b0;
    tick(n);
    reset_n  = 1'b1;
    r = cyc;
  endtask

  // Lock drop long enough to count as a loss in RUN, then recovery to RUN
  task automatic lock_loss();
    int unsigned l;
    l = cyc + 2 + LOSS_DLY;
    push(l,      8'b1_0_0_0_000_1);
    push(l + 4,  8'b0_0_0_0_000_1);
    push(l + 14, 8'b0_1_1_0_000_1);
    bus.lock = 1'b0;
    tick(DROP_LEN);
    bus.lock = 1'b1;
    tick(30);
  endtask

  // Monitor: sample away from the active edge and on async reset
  always begin
    @(negedge clk or negedge reset_n);
    #1;
    if (mon_en) begin
      cur = {bus.pll_rst, bus.sys_reset_n, bus.ready, bus.fail, bus.retry_cnt, bus.lock_lost};
      if (!have_prev || cur !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: outputs %b at cycle %0d, required no change", cur, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (cur !== mon_e.v) begin
            errors++;
            $display("FAIL out_value: got %b at cycle %0d, required %b", cur, cyc, mon_e.v);
          end
          checks++;
          if (cyc != mon_e.cyc) begin
            errors++;
            $display("FAIL out_timing: %b seen at cycle %0d, required cycle %0d", cur, cyc, mon_e.cyc);
          end
        end
      end
      prev      = cur;
      have_prev = 1'b1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned r;
    int unsigned n;
    bus.lock = 1'b0;
    #2;
    mon_en = 1'b1;

    // Power-on reset, lock never arrives: three pulses then FAIL
    hit_reset(3, r);
    push(r + 4,  8'b0_0_0_0_000_0);
    push(r + 24, 8'b1_0_0_0_001_0);
    push(r + 28, 8'b0_0_0_0_001_0);
    push(r + 48, 8'b1_0_0_0_010_0);
    push(r + 52, 8'b0_0_0_0_010_0);
    push(r + 72, 8'b0_0_0_1_010_0);
    tick(100);

    // Reset out of FAIL; lock 5 cycles after pll_rst falls
    hit_reset(2, r);
    push(r + 4, 8'b0_0_0_0_000_0);
    tick(4);
    tick(5);
    n = cyc;
    push(n + 12, 8'b0_1_1_0_000_0);
    bus.lock = 1'b1;
    tick(20);

`ifdef PLLSUP_GLITCH_FILTER_EN
    // Short drop in RUN must be filtered out entirely
    bus.lock = 1'b0;
    tick(3);
    bus.lock = 1'b1;
    tick(15);
`endif
    lock_loss();

    // Reset mid-RUN; one timeout retry, then a one-cycle drop in STABLE
    hit_reset(3, r);
    push(r + 4,  8'b0_0_0_0_000_0);
    push(r + 24, 8'b1_0_0_0_001_0);
    push(r + 28, 8'b0_0_0_0_001_0);
    tick(28);
    tick(2);
    n = cyc;
    push(n + 19, 8'b0_1_1_0_001_0);
    bus.lock = 1'b1;
    tick(6);
    bus.lock = 1'b0;
    tick(1);
    bus.lock = 1'b1;
    tick(20);

    // Loss in RUN clears the retry count
    lock_loss();
    tick(10);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: %0d outstanding, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
